ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), and checks for the device ACK. It sits beside the keyboard decoder on the same PS2_CLK/PS2_DATA pair. The top level ties each line as `oe ? 1'b0 : 1'bz` and feeds the pad value back to the `*_in` inputs. The decoder ignores traffic while tx_busy=1.

---
 rtl/ps2_host_tx.sv | 178 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// one command byte on device clocks, then check the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_TOP = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_n;
    logic [9:0]    frame, frame_n;
    logic [3:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          clk_s, data_s, fall;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    // Reset to the idle-high line level so no spurious fall appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    // State, frame, counters and registered line enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            frame     <= '0;
            idx       <= '0;
            cnt       <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_n;
            frame     <= frame_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
        end
    end

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // Next-state and next-output logic; line enables change only on transitions
    // and on detected device clock falls while sending.
    always_comb begin
        state_n   = state;
        frame_n   = frame;
        idx_n     = idx;
        cnt_n     = cnt;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        unique case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_start) begin
                    frame_n  = {1'b1, ~^tx_data, tx_data};
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_n = cnt_inc;
                if (cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b1;
                idx_n     = '0;
                cnt_n     = '0;
                state_n   = S_SEND;
            end
            S_SEND: begin
                cnt_n = cnt_inc;
                if (cnt >= TO_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    state_n   = S_ERR;
                end else if (fall) begin
                    data_oe_n = ~frame[idx];
                    idx_n     = idx + 1'b1;
                    if (idx == 4'd9) begin
                        state_n = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                cnt_n = cnt_inc;
                if (cnt >= TO_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    state_n   = S_ERR;
                end else if (fall) begin
                    state_n = data_s ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_n = cnt_inc;
                if (cnt >= TO_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    state_n   = S_ERR;
                end else if (clk_s && data_s) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERR: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    assign tx_busy     = (state != S_IDLE);
    assign tx_done     = (state == S_DONE);
    assign tx_err      = (state == S_ERR);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: device model on open-drain lines, vector table
// of command bytes plus directed timeout, busy and reset sequences.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic       dev_clk;
    logic       dev_data;

    int         n_checks;
    int         n_fail;
    int         n_done;
    int         n_err;
    int         n_both;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         inject;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Wired-AND open-drain lines: low if either side pulls.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result pulses seen between clock edges.
    always @(negedge clk) begin
        if (tx_done) n_done = n_done + 1;
        if (tx_err) n_err = n_err + 1;
        if (tx_done && tx_err) n_both = n_both + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Measure host-only clock hold and request cycles; optionally poke a
    // second start while the first transfer is inhibiting.
    task automatic meas_req(input bit inject, output int inh, output int req);
        inh = 0;
        req = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin
            if (inject && inh == 5) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            inh = inh + 1;
            @(negedge clk);
        end
        tx_start = 1'b0;
        while (ps2_clk_oe && ps2_data_oe && req < 100) begin
            req = req + 1;
            @(negedge clk);
        end
    endtask

    // Device side: 10 clocks sampling on rising edges, then ACK/NACK clock.
    task automatic dev_frame(input bit ack, output logic [9:0] bits);
        int g;
        g = 0;
        bits = '0;
        while (!(!ps2_clk_oe && ps2_data_oe) && g < 200) begin
            g = g + 1;
            @(negedge clk);
        end
        check("req_seen", {31'd0, (g < 200)}, 32'd1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = ps2_data_in;
            repeat (20) @(negedge clk);
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (tx_busy && g < 500) begin
            g = g + 1;
            @(negedge clk);
        end
        check(name, {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int inh;
        int req;
        logic [9:0] bits;
        n_done = 0;
        n_err  = 0;
        do_start(v.data);
        check("busy_accept", {31'd0, tx_busy}, 32'd1);
        meas_req(v.inject, inh, req);
        check("inhibit_len", inh, 20);
        check("req_len", req, 1);
        check("send_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("send_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        dev_frame(v.ack, bits);
        wait_idle("busy_end");
        check("frame_bits", {22'd0, bits}, {22'd0, v.exp_bits});
        check("done_count", n_done, v.exp_done);
        check("err_count", n_err, v.exp_err);
        check("clk_oe_end", {31'd0, ps2_clk_oe}, 32'd0);
        check("data_oe_end", {31'd0, ps2_data_oe}, 32'd0);
        repeat (40) @(negedge clk);
        check("no_requeue", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        int k;
        int inh;
        int req;
        n_checks = 0;
        n_fail   = 0;
        n_done   = 0;
        n_err    = 0;
        n_both   = 0;
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;

        //            data   ack inj  {stop,par,data}
        vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h3ED, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 10'h201, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 10'h300, 1, 0};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, 10'h2F4, 0, 1};
        vecs[4] = '{8'hF4, 1'b1, 1'b1, 10'h2F4, 1, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 10'h3FF, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_err", {31'd0, tx_err}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Silent device: error exactly TIMEOUT cycles after clock release.
        n_done = 0;
        n_err  = 0;
        do_start(8'h12);
        meas_req(1'b0, inh, req);
        check("to_inhibit_len", inh, 20);
        k = 0;
        while (!tx_err && k < 6000) begin
            @(negedge clk);
            k = k + 1;
        end
        check("timeout_cycles", k, 5000);
        check("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        @(negedge clk);
        check("to_busy", {31'd0, tx_busy}, 32'd0);
        check("to_err_width", {31'd0, tx_err}, 32'd0);
        check("to_done_count", n_done, 0);

        // Reset at the 5th device clock fall releases everything next edge.
        n_done = 0;
        do_start(8'hA5);
        meas_req(1'b0, inh, req);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("mrst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("mrst_busy", {31'd0, tx_busy}, 32'd0);
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        check("mrst_done_count", n_done, 0);

        run_vec(vecs[5]);

        check("done_err_overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
